// File: rtl/max_pool_stream.sv
// 2x2 / stride-2 streaming max-pool over CHANNELS parallel signed feature channels.
// Optional ReLU fused after pooling when the POOL_RELU_EN macro is defined.
module max_pool_stream #(
    parameter int CHANNELS = 6,
    parameter int DATA_W   = 8,
    parameter int IN_W     = 28,
    parameter int IN_H     = 28
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_feature_valid,
    input  logic [CHANNELS*DATA_W-1:0]   i_features,
    output logic                         o_ready,
    output logic                         o_feature_valid,
    output logic [CHANNELS*DATA_W-1:0]   o_features,
    output logic                         o_last,
    input  logic                         i_ready
);

    localparam int VEC_W    = CHANNELS * DATA_W;
    localparam int COL_W    = (IN_W > 2) ? $clog2(IN_W) : 1;
    localparam int ROW_W    = (IN_H > 2) ? $clog2(IN_H) : 1;
    localparam int LB_AW    = (COL_W > 1) ? COL_W - 1 : 1;
    localparam int LB_DEPTH = 1 << LB_AW;

    if ((IN_W < 2) || ((IN_W % 2) != 0)) begin : g_bad_in_w
        $error("max_pool_stream: IN_W must be even and >= 2");
    end
    if ((IN_H < 2) || ((IN_H % 2) != 0)) begin : g_bad_in_h
        $error("max_pool_stream: IN_H must be even and >= 2");
    end

    function automatic logic [VEC_W-1:0] vec_max(input logic [VEC_W-1:0] a,
                                                 input logic [VEC_W-1:0] b);
        logic signed [DATA_W-1:0] ea;
        logic signed [DATA_W-1:0] eb;
        vec_max = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ea = a[c*DATA_W +: DATA_W];
            eb = b[c*DATA_W +: DATA_W];
            vec_max[c*DATA_W +: DATA_W] = (ea > eb) ? ea : eb;
        end
    endfunction

    function automatic logic [VEC_W-1:0] vec_relu(input logic [VEC_W-1:0] a);
`ifdef POOL_RELU_EN
        logic signed [DATA_W-1:0] ea;
        vec_relu = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            ea = a[c*DATA_W +: DATA_W];
            vec_relu[c*DATA_W +: DATA_W] = (ea < 0) ? '0 : ea;
        end
`else
        vec_relu = a;
`endif
    endfunction

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [VEC_W-1:0]  pair_p0;
    logic [VEC_W-1:0]  linebuf [LB_DEPTH];
    logic [LB_AW-1:0]  lb_idx;
    logic [VEC_W-1:0]  lb_rd;
    logic [VEC_W-1:0]  win_max;
    logic              accept;
    logic              phase_even_b;
    logic              phase_odd_b;
    logic              frame_end;
    logic              vld_p1;
    logic [VEC_W-1:0]  feat_p1;
    logic              last_p1;

    // An ODD_B beat can only be accepted when the output slot is free or draining.
    assign o_ready      = !vld_p1 || i_ready;
    assign accept       = i_feature_valid && o_ready;
    assign phase_even_b = !row[0] && col[0];
    assign phase_odd_b  = row[0] && col[0];
    assign frame_end    = (row == ROW_W'(IN_H - 1)) && (col == COL_W'(IN_W - 1));
    assign lb_idx       = LB_AW'(col >> 1);
    assign lb_rd        = linebuf[lb_idx];
    assign win_max      = vec_max(vec_max(pair_p0, i_features), lb_rd);

    // Stage p0: raster counters and horizontal pair register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            col     <= '0;
            row     <= '0;
            pair_p0 <= '0;
        end else if (accept) begin
            if (!col[0]) begin
                pair_p0 <= i_features;
            end
            if (col == COL_W'(IN_W - 1)) begin
                col <= '0;
                row <= (row == ROW_W'(IN_H - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    // Even-row pair maxima; always written before the odd row reads them
    always_ff @(posedge i_clk) begin
        if (accept && phase_even_b) begin
            linebuf[lb_idx] <= vec_max(pair_p0, i_features);
        end
    end

    // Stage p1: one-deep output register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            vld_p1  <= 1'b0;
            feat_p1 <= '0;
            last_p1 <= 1'b0;
        end else if (accept && phase_odd_b) begin
            vld_p1  <= 1'b1;
            feat_p1 <= vec_relu(win_max);
            last_p1 <= frame_end;
        end else if (vld_p1 && i_ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign o_feature_valid = vld_p1;
    assign o_features      = feat_p1;
    assign o_last          = last_p1;

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: literal checks on a 4x4 instance, and a window-level
// reference model checking a default 28x28 instance every cycle.
module tb_max_pool_stream;

    localparam int CH  = 6;
    localparam int DW  = 8;
    localparam int W   = 28;
    localparam int H   = 28;
    localparam int VW  = CH * DW;
    localparam int FR  = W * H;
    localparam int SCH = 2;
    localparam int SVW = SCH * DW;
`ifdef POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          iv, ordy, ov, olast, ir;
    logic [VW-1:0] ifeat, ofeat;
    logic          s_iv, s_ordy, s_ov, s_ol, s_ir;
    logic [SVW-1:0] s_if, s_of;

    max_pool_stream #(.CHANNELS(CH), .DATA_W(DW), .IN_W(W), .IN_H(H)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_feature_valid(iv), .i_features(ifeat),
        .o_ready(ordy), .o_feature_valid(ov), .o_features(ofeat), .o_last(olast),
        .i_ready(ir)
    );

    max_pool_stream #(.CHANNELS(SCH), .DATA_W(DW), .IN_W(4), .IN_H(4)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_feature_valid(s_iv), .i_features(s_if),
        .o_ready(s_ordy), .o_feature_valid(s_ov), .o_features(s_of), .o_last(s_ol),
        .i_ready(s_ir)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed [DW-1:0] post(input logic signed [DW-1:0] v);
        if (RELU && v < 0) return '0;
        return v;
    endfunction

    // Reference model: keep the whole frame, pool each window when it completes
    logic signed [DW-1:0] fr [H][W][CH];
    logic [VW-1:0]        exp_q[$];
    bit                   lastq[$];
    int                   bc = 0;
    int                   out_cnt = 0;
    int                   last_pos[$];
    bit                   prev_load = 0, prev_hold = 0;
    logic [VW-1:0]        held, e, front;
    logic                 held_last;
    int                   r, c;
    logic signed [DW-1:0] m;

    always @(negedge clk) begin
        if (!rst_n) begin
            bc = 0;
            exp_q.delete();
            lastq.delete();
            prev_load = 0;
            prev_hold = 0;
        end else begin
            if (prev_load) chk(ov === 1'b1, "latency", ov, 1);
            if (prev_hold) begin
                chk(ov === 1'b1, "hold_valid", ov, 1);
                chk(ofeat === held, "hold_data", ofeat, held);
                chk(olast === held_last, "hold_last", olast, held_last);
            end
            chk(ordy === (!ov || ir), "ready_rule", ordy, !ov || ir);
            if (ov && ir) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    chk(0, "extra_output", out_cnt, 0);
                end else begin
                    front = exp_q.pop_front();
                    chk(ofeat === front, "data", ofeat, front);
                    chk(olast === lastq[0], "last", olast, lastq[0]);
                    void'(lastq.pop_front());
                end
                if (olast) last_pos.push_back(out_cnt);
            end
            prev_hold = ov && !ir;
            held      = ofeat;
            held_last = olast;
            prev_load = 0;
            if (iv && ordy) begin
                r = bc / W;
                c = bc % W;
                for (int k = 0; k < CH; k++) fr[r][c][k] = ifeat[k*DW +: DW];
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    for (int k = 0; k < CH; k++) begin
                        m = fr[r-1][c-1][k];
                        if (fr[r-1][c][k] > m) m = fr[r-1][c][k];
                        if (fr[r][c-1][k] > m) m = fr[r][c-1][k];
                        if (fr[r][c][k] > m)   m = fr[r][c][k];
                        e[k*DW +: DW] = post(m);
                    end
                    exp_q.push_back(e);
                    lastq.push_back(bc == FR - 1);
                    prev_load = 1;
                end
                bc = (bc + 1) % FR;
            end
        end
    end

    logic [SVW-1:0] s_oq[$];
    bit             s_lq[$];
    always @(negedge clk) begin
        if (rst_n && s_ov && s_ir) begin
            s_oq.push_back(s_of);
            s_lq.push_back(s_ol);
        end
    end

    task automatic drive_beats(input int nbeats, input int pv, input int pr, output int cyc);
        int n;
        logic [15:0] v;
        n   = 0;
        cyc = 0;
        while (n < nbeats) begin
            @(posedge clk);
            #1;
            iv = ($urandom_range(99) < pv);
            ir = ($urandom_range(99) < pr);
            for (int k = 0; k < CH; k++) begin
                v = 16'($urandom);
                if (v[3:0] == 4'd0)      ifeat[k*DW +: DW] = 8'h80;
                else if (v[3:0] == 4'd1) ifeat[k*DW +: DW] = 8'h7f;
                else                     ifeat[k*DW +: DW] = v[15:8];
            end
            @(negedge clk);
            if (iv && ordy) n++;
            cyc++;
            if (cyc > nbeats * 30 + 200) begin
                chk(0, "beat_timeout", n, nbeats);
                break;
            end
        end
    endtask

    task automatic drain();
        @(posedge clk);
        #1;
        iv = 0;
        ir = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !ov) break;
        end
        chk(exp_q.size() == 0 && !ov, "drain", exp_q.size(), 0);
    endtask

    task automatic s_frame(input int kind);
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            s_iv = 1;
            if (kind == 0) begin
                s_if = {8'(-i), 8'(i)};
            end else begin
                case (i)
                    0:       s_if = {8'(i), 8'h80};
                    1:       s_if = {8'(i), 8'hff};
                    4:       s_if = {8'(i), 8'hce};
                    5:       s_if = {8'(i), 8'h81};
                    default: s_if = {8'(i), 8'hfb};
                endcase
            end
            @(negedge clk);
            chk(s_ordy === 1'b1, "s_ready", s_ordy, 1);
        end
        @(posedge clk);
        #1;
        s_iv = 0;
        repeat (3) @(negedge clk);
    endtask

    int             e0[4] = '{5, 7, 13, 15};
    int             e1[4] = '{0, -2, -8, -10};
    logic [SVW-1:0] sv;
    int             cyc, saved;

    initial begin
        rst_n = 0; iv = 0; ir = 1; ifeat = '0;
        s_iv = 0; s_ir = 1; s_if = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk(ov === 1'b0, "rst_valid", ov, 0);
        chk(olast === 1'b0, "rst_last", olast, 0);
        chk(ofeat === '0, "rst_data", ofeat, 0);
        chk(ordy === 1'b1, "rst_ready", ordy, 1);
        chk(s_ov === 1'b0, "s_rst_valid", s_ov, 0);
        chk(s_of === '0, "s_rst_data", s_of, 0);

        // 4x4 ramp frame
        s_frame(0);
        chk(s_oq.size() == 4, "s_count1", s_oq.size(), 4);
        for (int k = 0; k < 4 && k < s_oq.size(); k++) begin
            sv = s_oq[k];
            chk(sv[7:0] == 8'(e0[k]), "s_ch0", sv[7:0], 8'(e0[k]));
            chk(sv[15:8] == (RELU ? 8'h00 : 8'(e1[k])), "s_ch1", sv[15:8],
                RELU ? 8'h00 : 8'(e1[k]));
            chk(s_lq[k] == (k == 3), "s_last", s_lq[k], k == 3);
        end
        // 4x4 frame whose first window is all negative
        s_frame(1);
        chk(s_oq.size() == 8, "s_count2", s_oq.size(), 8);
        if (s_oq.size() == 8) begin
            sv = s_oq[4];
            chk(sv[7:0] == (RELU ? 8'h00 : 8'hff), "s_neg_window", sv[7:0],
                RELU ? 8'h00 : 8'hff);
            chk(s_lq[7] == 1'b1, "s_last2", s_lq[7], 1);
        end

        // Backpressure on the first output of a 28x28 frame
        out_cnt = 0;
        last_pos.delete();
        drive_beats(30, 100, 100, cyc);
        @(posedge clk);
        #1;
        ir = 0;
        iv = 1;
        saved = bc;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            chk(ov === 1'b1, "bp_valid", ov, 1);
            chk(ordy === 1'b0, "bp_ready", ordy, 0);
        end
        chk(bc == saved, "bp_no_consume", bc, saved);
        drive_beats(FR - 30, 100, 100, cyc);
        drain();
        chk(out_cnt == 196, "bp_count", out_cnt, 196);
        chk(last_pos.size() == 1 && last_pos[0] == 196, "bp_last_pos", last_pos.size(), 1);

        // Two frames back to back at full rate
        out_cnt = 0;
        last_pos.delete();
        drive_beats(2 * FR, 100, 100, cyc);
        chk(cyc == 2 * FR, "throughput", cyc, 2 * FR);
        drain();
        chk(out_cnt == 392, "b2b_count", out_cnt, 392);
        chk(last_pos.size() == 2 && last_pos[0] == 196 && last_pos[1] == 392,
            "b2b_last_pos", last_pos.size(), 2);

        // Reset after 37 beats of a frame
        drive_beats(37, 100, 100, cyc);
        @(posedge clk);
        #1;
        rst_n = 0;
        iv = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        @(negedge clk);
        chk(ov === 1'b0, "midrst_valid", ov, 0);
        chk(ordy === 1'b1, "midrst_ready", ordy, 1);
        out_cnt = 0;
        last_pos.delete();
        drive_beats(FR, 100, 100, cyc);
        drain();
        chk(out_cnt == 196, "midrst_count", out_cnt, 196);
        chk(last_pos.size() == 1 && last_pos[0] == 196, "midrst_last", last_pos.size(), 1);

        // Ten frames with random valid/ready
        out_cnt = 0;
        last_pos.delete();
        drive_beats(10 * FR, 50, 50, cyc);
        drain();
        chk(out_cnt == 1960, "rand_count", out_cnt, 1960);
        chk(last_pos.size() == 10, "rand_lasts", last_pos.size(), 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
